// File: rtl/wb_port_arbiter.sv
// Register-file writeback arbiter: merges the in-order pipe result with a 2-entry FIFO of
// late (multi-cycle) results, with a starvation guard so buffered results cannot wait forever.
module wb_port_arbiter (
    input  logic        clk,
    input  logic        resetn,
    input  logic        pipe_valid,
    input  logic [4:0]  pipe_dst,
    input  logic [31:0] pipe_val,
    input  logic [3:0]  pipe_we,
    output logic        pipe_stall,
    input  logic        late_valid,
    output logic        late_ready,
    input  logic [4:0]  late_dst,
    input  logic [31:0] late_val,
    input  logic [3:0]  late_we,
    output logic [3:0]  rf_we,
    output logic [4:0]  rf_dst,
    output logic [31:0] rf_val,
    output logic [1:0]  pend_cnt
);

    typedef struct packed {
        logic [4:0]  dst;
        logic [31:0] val;
        logic [3:0]  we;
    } entry_t;

    entry_t      fifo_q [2];
    entry_t      fifo_d [2];
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic [1:0]  pend_cnt_q, pend_cnt_d;
    logic [1:0]  starve_q, starve_d;
    logic [3:0]  rf_we_q, rf_we_d;
    logic [4:0]  rf_dst_q, rf_dst_d;
    logic [31:0] rf_val_q, rf_val_d;

    logic   pipe_write;
    logic   fifo_ne;
    logic   push;
    logic   grant_late;
    logic   grant_pipe;
    entry_t head;

    always_comb begin
        fifo_d     = fifo_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        rf_we_d    = 4'b0;
        rf_dst_d   = rf_dst_q;
        rf_val_d   = rf_val_q;

        pipe_write = pipe_valid && (pipe_we != 4'b0);
        fifo_ne    = (pend_cnt_q != 2'd0);
        head       = fifo_q[rd_ptr_q];

        // While in reset, present the post-reset view of the handshakes.
        late_ready = !resetn || (pend_cnt_q < 2'd2);
        push       = late_valid && late_ready;

        grant_late = fifo_ne && ((starve_q == 2'd3) || !pipe_write);
        grant_pipe = pipe_write && !grant_late;
        pipe_stall = resetn && pipe_write && grant_late;

        if (grant_late) begin
            rf_we_d  = (head.dst == 5'd0) ? 4'b0 : head.we;
            rf_dst_d = head.dst;
            rf_val_d = head.val;
            rd_ptr_d = ~rd_ptr_q;
        end else if (grant_pipe) begin
            rf_we_d  = (pipe_dst == 5'd0) ? 4'b0 : pipe_we;
            rf_dst_d = pipe_dst;
            rf_val_d = pipe_val;
        end

        if (push) begin
            fifo_d[wr_ptr_q] = '{dst: late_dst, val: late_val, we: late_we};
            wr_ptr_d         = ~wr_ptr_q;
        end

        pend_cnt_d = pend_cnt_q + {1'b0, push} - {1'b0, grant_late};

        if (!fifo_ne || grant_late) begin
            starve_d = 2'd0;
        end else if (starve_q == 2'd3) begin
            starve_d = 2'd3;
        end else begin
            starve_d = starve_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            fifo_q[0]  <= '0;
            fifo_q[1]  <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            pend_cnt_q <= 2'd0;
            starve_q   <= 2'd0;
            rf_we_q    <= 4'b0;
            rf_dst_q   <= 5'd0;
            rf_val_q   <= 32'd0;
        end else begin
            fifo_q     <= fifo_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            pend_cnt_q <= pend_cnt_d;
            starve_q   <= starve_d;
            rf_we_q    <= rf_we_d;
            rf_dst_q   <= rf_dst_d;
            rf_val_q   <= rf_val_d;
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_dst   = rf_dst_q;
    assign rf_val   = rf_val_q;
    assign pend_cnt = pend_cnt_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: stimulus queues expected register-file writes (with the
// cycle they must appear in); a negedge monitor pops and compares every write the DUT makes.
module tb_wb_port_arbiter;

    logic        clk;
    logic        resetn;
    logic        pipe_valid;
    logic [4:0]  pipe_dst;
    logic [31:0] pipe_val;
    logic [3:0]  pipe_we;
    logic        pipe_stall;
    logic        late_valid;
    logic        late_ready;
    logic [4:0]  late_dst;
    logic [31:0] late_val;
    logic [3:0]  late_we;
    logic [3:0]  rf_we;
    logic [4:0]  rf_dst;
    logic [31:0] rf_val;
    logic [1:0]  pend_cnt;

    wb_port_arbiter dut (
        .clk        (clk),
        .resetn     (resetn),
        .pipe_valid (pipe_valid),
        .pipe_dst   (pipe_dst),
        .pipe_val   (pipe_val),
        .pipe_we    (pipe_we),
        .pipe_stall (pipe_stall),
        .late_valid (late_valid),
        .late_ready (late_ready),
        .late_dst   (late_dst),
        .late_val   (late_val),
        .late_we    (late_we),
        .rf_we      (rf_we),
        .rf_dst     (rf_dst),
        .rf_val     (rf_val),
        .pend_cnt   (pend_cnt)
    );

    typedef struct {
        int          cyc;
        logic [3:0]  we;
        logic [4:0]  dst;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, req, cyc);
    endtask

    task automatic expect_wr(input int c, input logic [3:0] we, input logic [4:0] dst,
                             input logic [31:0] val);
        exp_t e;
        e.cyc = c;
        e.we  = we;
        e.dst = dst;
        e.val = val;
        exp_q.push_back(e);
    endtask

    // Monitor: every nonzero register-file write must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rf_we !== 4'b0) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                $display("FAIL rf_write: unexpected we=%h dst=%0d val=0x%0h at cycle %0d",
                         rf_we, rf_dst, rf_val, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (e.cyc == cyc && e.we === rf_we && e.dst === rf_dst && e.val === rf_val)
                    n_pass++;
                else
                    $display("FAIL rf_write: got cyc=%0d we=%h dst=%0d val=0x%0h, want cyc=%0d we=%h dst=%0d val=0x%0h",
                             cyc, rf_we, rf_dst, rf_val, e.cyc, e.we, e.dst, e.val);
            end
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pipe(input logic v, input logic [4:0] d, input logic [31:0] x,
                            input logic [3:0] w);
        pipe_valid = v;
        pipe_dst   = d;
        pipe_val   = x;
        pipe_we    = w;
    endtask

    task automatic set_late(input logic v, input logic [4:0] d, input logic [31:0] x,
                            input logic [3:0] w);
        late_valid = v;
        late_dst   = d;
        late_val   = x;
        late_we    = w;
    endtask

    initial begin
        resetn = 1'b0;
        set_pipe(1'b1, 5'd3, 32'h33, 4'hF);
        set_late(1'b0, 5'd0, 32'h0, 4'h0);
        nxt();
        nxt();
        #1;
        chk("reset_rf_we", {28'd0, rf_we}, 32'd0);
        chk("reset_rf_dst", {27'd0, rf_dst}, 32'd0);
        chk("reset_rf_val", rf_val, 32'd0);
        chk("reset_pend_cnt", {30'd0, pend_cnt}, 32'd0);
        chk("reset_late_ready", {31'd0, late_ready}, 32'd1);
        chk("reset_pipe_stall", {31'd0, pipe_stall}, 32'd0);
        set_pipe(1'b0, 5'd0, 32'h0, 4'h0);
        resetn = 1'b1;

        // Pipe only.
        nxt();
        set_pipe(1'b1, 5'd5, 32'h1234, 4'hF);
        #1 chk("pipe_only_stall", {31'd0, pipe_stall}, 32'd0);
        expect_wr(cyc + 1, 4'hF, 5'd5, 32'h1234);
        nxt();
        set_pipe(1'b0, 5'd0, 32'h0, 4'h0);
        #1 chk("pipe_only_rf_dst", {27'd0, rf_dst}, 32'd5);

        // Idle drain of one late result.
        nxt();
        set_late(1'b1, 5'd8, 32'hAA, 4'hF);
        #1 chk("drain_late_ready", {31'd0, late_ready}, 32'd1);
        expect_wr(cyc + 2, 4'hF, 5'd8, 32'hAA);
        nxt();
        set_late(1'b0, 5'd0, 32'h0, 4'h0);
        #1 chk("drain_pend1", {30'd0, pend_cnt}, 32'd1);
        nxt();
        #1 chk("drain_pend0", {30'd0, pend_cnt}, 32'd0);

        // Starvation: pipe writes every cycle, late forced at starve==3.
        nxt();
        set_late(1'b1, 5'd9, 32'h99, 4'hF);
        set_pipe(1'b1, 5'd1, 32'h101, 4'hF);
        expect_wr(cyc + 1, 4'hF, 5'd1, 32'h101);
        nxt();
        set_late(1'b0, 5'd0, 32'h0, 4'h0);
        for (int k = 2; k <= 4; k++) begin
            set_pipe(1'b1, 5'(k), 32'h100 + 32'(k), 4'hF);
            #1 chk("starve_pipe_wins", {31'd0, pipe_stall}, 32'd0);
            expect_wr(cyc + 1, 4'hF, 5'(k), 32'h100 + 32'(k));
            nxt();
        end
        set_pipe(1'b1, 5'd5, 32'h105, 4'hF);
        #1 chk("starve_forced_stall", {31'd0, pipe_stall}, 32'd1);
        expect_wr(cyc + 1, 4'hF, 5'd9, 32'h99);
        nxt();
        #1 chk("starve_pipe_after", {31'd0, pipe_stall}, 32'd0);
        expect_wr(cyc + 1, 4'hF, 5'd5, 32'h105);
        nxt();
        set_pipe(1'b0, 5'd0, 32'h0, 4'h0);

        // Full FIFO with a busy pipe; third late result waits for a pop.
        set_late(1'b1, 5'd10, 32'hA0, 4'h3);
        set_pipe(1'b1, 5'd11, 32'h1100, 4'hF);
        #1 chk("full_ready0", {31'd0, late_ready}, 32'd1);
        expect_wr(cyc + 1, 4'hF, 5'd11, 32'h1100);
        nxt();
        set_late(1'b1, 5'd12, 32'hB0, 4'hF);
        set_pipe(1'b1, 5'd11, 32'h1101, 4'hF);
        #1 chk("full_ready1", {31'd0, late_ready}, 32'd1);
        expect_wr(cyc + 1, 4'hF, 5'd11, 32'h1101);
        nxt();
        set_late(1'b1, 5'd13, 32'hC0, 4'hF);
        set_pipe(1'b1, 5'd11, 32'h1102, 4'hF);
        #1 chk("full_pend2", {30'd0, pend_cnt}, 32'd2);
        chk("full_not_ready", {31'd0, late_ready}, 32'd0);
        expect_wr(cyc + 1, 4'hF, 5'd11, 32'h1102);
        nxt();
        set_pipe(1'b1, 5'd11, 32'h1103, 4'hF);
        #1 chk("full_not_ready2", {31'd0, late_ready}, 32'd0);
        expect_wr(cyc + 1, 4'hF, 5'd11, 32'h1103);
        nxt();
        set_pipe(1'b1, 5'd11, 32'h1104, 4'hF);
        #1 chk("full_forced_stall", {31'd0, pipe_stall}, 32'd1);
        expect_wr(cyc + 1, 4'h3, 5'd10, 32'hA0);
        nxt();
        #1 chk("full_stall_clear", {31'd0, pipe_stall}, 32'd0);
        chk("full_ready_after_pop", {31'd0, late_ready}, 32'd1);
        chk("full_pend_after_pop", {30'd0, pend_cnt}, 32'd1);
        expect_wr(cyc + 1, 4'hF, 5'd11, 32'h1104);
        nxt();
        set_late(1'b0, 5'd0, 32'h0, 4'h0);
        set_pipe(1'b0, 5'd0, 32'h0, 4'h0);
        #1 chk("full_pend_refill", {30'd0, pend_cnt}, 32'd2);
        expect_wr(cyc + 1, 4'hF, 5'd12, 32'hB0);
        nxt();
        #1 chk("full_pend_drain1", {30'd0, pend_cnt}, 32'd1);
        expect_wr(cyc + 1, 4'hF, 5'd13, 32'hC0);
        nxt();
        #1 chk("full_pend_drain0", {30'd0, pend_cnt}, 32'd0);

        // Push and pop together at count 1; pipe_valid with no byte enables never stalls.
        set_late(1'b1, 5'd14, 32'hD0, 4'hF);
        nxt();
        set_late(1'b1, 5'd15, 32'hE0, 4'hC);
        set_pipe(1'b1, 5'd7, 32'h777, 4'h0);
        #1 chk("pp_no_we_stall", {31'd0, pipe_stall}, 32'd0);
        chk("pp_pend_before", {30'd0, pend_cnt}, 32'd1);
        expect_wr(cyc + 1, 4'hF, 5'd14, 32'hD0);
        nxt();
        set_late(1'b0, 5'd0, 32'h0, 4'h0);
        set_pipe(1'b0, 5'd0, 32'h0, 4'h0);
        #1 chk("pp_pend_stays1", {30'd0, pend_cnt}, 32'd1);
        expect_wr(cyc + 1, 4'hC, 5'd15, 32'hE0);
        nxt();
        #1 chk("pp_pend_drained", {30'd0, pend_cnt}, 32'd0);

        // Pipe write to x0 is consumed but not written.
        set_pipe(1'b1, 5'd0, 32'hDEAD, 4'hF);
        #1 chk("zero_dst_stall", {31'd0, pipe_stall}, 32'd0);
        nxt();
        set_pipe(1'b0, 5'd0, 32'h0, 4'h0);
        #1 chk("zero_dst_rf_we", {28'd0, rf_we}, 32'd0);

        // Reset mid-operation discards both buffered results.
        nxt();
        set_late(1'b1, 5'd16, 32'h160, 4'hF);
        set_pipe(1'b1, 5'd17, 32'h170, 4'hF);
        expect_wr(cyc + 1, 4'hF, 5'd17, 32'h170);
        nxt();
        set_late(1'b1, 5'd18, 32'h180, 4'hF);
        set_pipe(1'b1, 5'd17, 32'h171, 4'hF);
        expect_wr(cyc + 1, 4'hF, 5'd17, 32'h171);
        nxt();
        set_late(1'b0, 5'd0, 32'h0, 4'h0);
        set_pipe(1'b1, 5'd19, 32'h190, 4'hF);
        resetn = 1'b0;
        #1 chk("rst_mid_pend2", {30'd0, pend_cnt}, 32'd2);
        chk("rst_mid_late_ready", {31'd0, late_ready}, 32'd1);
        chk("rst_mid_stall", {31'd0, pipe_stall}, 32'd0);
        nxt();
        resetn = 1'b1;
        set_pipe(1'b0, 5'd0, 32'h0, 4'h0);
        #1 chk("rst_after_pend", {30'd0, pend_cnt}, 32'd0);
        chk("rst_after_rf_we", {28'd0, rf_we}, 32'd0);
        chk("rst_after_rf_dst", {27'd0, rf_dst}, 32'd0);
        chk("rst_after_late_ready", {31'd0, late_ready}, 32'd1);
        for (int i = 0; i < 6; i++) nxt();
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
